// File: rtl/sentinel_multi_limit.sv
// sentinel_multi_limit: inline AXI4-Stream risk gate with a per-destination limit,
// an optional cumulative-exposure mode, hitless limit updates and AXI4-Lite
// access to the control, forensic and exposure registers.
module sentinel_multi_limit #(
  parameter int NUM_DEST = 8,
  parameter int AMT_W    = 40,
  parameter int ID_LSB   = 40,
  parameter int EXP_W    = 48
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [63:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  input  logic        s_axis_tlast,
  output logic        s_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready,
  input  logic [31:0] s_axil_awaddr,
  input  logic        s_axil_awvalid,
  output logic        s_axil_awready,
  input  logic [31:0] s_axil_wdata,
  input  logic [3:0]  s_axil_wstrb,
  input  logic        s_axil_wvalid,
  output logic        s_axil_wready,
  output logic [1:0]  s_axil_bresp,
  output logic        s_axil_bvalid,
  input  logic        s_axil_bready,
  input  logic [31:0] s_axil_araddr,
  input  logic        s_axil_arvalid,
  output logic        s_axil_arready,
  output logic [31:0] s_axil_rdata,
  output logic [1:0]  s_axil_rresp,
  output logic        s_axil_rvalid,
  input  logic        s_axil_rready
);
  localparam int IDX_W = $clog2(NUM_DEST);
  localparam int CW    = EXP_W + 1;
  localparam logic [31:0] LIMIT_RST = 32'd1000;

  // Exposure accumulation clamps at the top of the EXP_W range.
  function automatic logic [EXP_W-1:0] sat_acc(input logic [CW-1:0] sum);
    return sum[EXP_W] ? {EXP_W{1'b1}} : sum[EXP_W-1:0];
  endfunction

  // Byte-lane merge for LIMIT writes.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] strb);
    logic [31:0] r;
    for (int b = 0; b < 4; b++) r[8*b +: 8] = strb[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    return r;
  endfunction

  logic [3:0]       ctrl_q;          // {strict, clear(always 0), cumulative, enable}
  logic [31:0]      viol_q;
  logic [63:0]      snap_q;
  logic [1:0]       rsn_code_q;
  logic [IDX_W-1:0] rsn_idx_q;
  logic [31:0]      limit_q [NUM_DEST];
  logic [31:0]      act_q   [NUM_DEST];
  logic [EXP_W-1:0] exp_q   [NUM_DEST];
  logic             open_q, open_d, pass_q, pass_d;
  logic             m_tvalid_q, m_tvalid_d, m_tlast_q, m_tlast_d;
  logic [63:0]      m_tdata_q, m_tdata_d;
  logic             awready_q, bvalid_q, arready_q, rvalid_q;
  logic [31:0]      rdata_q, rd_val;
  logic [63:0]      rd_exp;

  // Header decode and limit comparison (EXP_W+1 bits, unsigned).
  logic             accept, hdr, unknown, over, drop, pass_now, lim_upd, acc_en;
  logic [15:0]      dest_id;
  logic [IDX_W-1:0] hdr_idx;
  logic [CW-1:0]    amt_c, lim_c, expo_c;

  assign s_axis_tready = m_axis_tready | ~m_tvalid_q;
  assign accept   = s_axis_tvalid & s_axis_tready;
  assign hdr      = accept & ~open_q;
  assign dest_id  = s_axis_tdata[ID_LSB +: 16];
  assign hdr_idx  = s_axis_tdata[ID_LSB +: IDX_W];
  assign amt_c    = CW'(s_axis_tdata[AMT_W-1:0]);
  assign lim_c    = CW'(act_q[hdr_idx]);
  assign expo_c   = CW'(exp_q[hdr_idx]) + amt_c;
  assign unknown  = ctrl_q[3] && (dest_id >= 16'(NUM_DEST));
  assign over     = ctrl_q[1] ? (expo_c > lim_c) : (amt_c > lim_c);
  assign drop     = ctrl_q[0] && (unknown || over);
  assign pass_now = hdr ? ~drop : pass_q;
  assign acc_en   = hdr && ctrl_q[0] && ctrl_q[1] && !drop;
  // Active limits only move at packet boundaries or while the gate is bypassed.
  assign lim_upd  = (!open_q && !hdr) || (accept && s_axis_tlast) || !ctrl_q[0];

  // AXI-Lite write/read decode.
  logic        wr_fire, rd_fire, ctrl_wr, lim_wr, clr_exp, rd_lim_ok, rd_exp_ok;
  logic [11:0] wa, ra;
  logic [IDX_W-1:0] wr_idx;
  logic        unused_ok;

  assign wa        = s_axil_awaddr[11:0];
  assign ra        = s_axil_araddr[11:0];
  assign wr_fire   = awready_q & s_axil_awvalid & s_axil_wvalid;
  assign rd_fire   = arready_q & s_axil_arvalid;
  assign ctrl_wr   = wr_fire && (wa == 12'h000);
  assign lim_wr    = wr_fire && (wa[11:8] == 4'h1) && ({26'd0, wa[7:2]} < 32'(NUM_DEST));
  assign wr_idx    = wa[2 +: IDX_W];
  assign clr_exp   = ctrl_wr && s_axil_wstrb[0] && s_axil_wdata[2];
  assign rd_lim_ok = {26'd0, ra[7:2]} < 32'(NUM_DEST);
  assign rd_exp_ok = {26'd0, ra[8:3]} < 32'(NUM_DEST);
  assign unused_ok = ^{s_axil_awaddr[31:12], s_axil_awaddr[1:0],
                       s_axil_araddr[31:12], s_axil_araddr[1:0]};

  assign s_axil_awready = awready_q;
  assign s_axil_wready  = awready_q;
  assign s_axil_bvalid  = bvalid_q;
  assign s_axil_bresp   = 2'b00;
  assign s_axil_arready = arready_q;
  assign s_axil_rvalid  = rvalid_q;
  assign s_axil_rdata   = rdata_q;
  assign s_axil_rresp   = 2'b00;
  assign m_axis_tvalid  = m_tvalid_q;
  assign m_axis_tdata   = m_tdata_q;
  assign m_axis_tlast   = m_tlast_q;

  // Next state of packet tracking and the one-deep output register.
  always_comb begin
    open_d     = open_q;
    pass_d     = pass_q;
    m_tvalid_d = m_tvalid_q;
    m_tdata_d  = m_tdata_q;
    m_tlast_d  = m_tlast_q;
    if (accept) begin
      open_d = ~s_axis_tlast;
      if (hdr) pass_d = ~drop;
    end
    if (s_axis_tready) begin
      m_tvalid_d = accept && pass_now;
      if (accept && pass_now) begin
        m_tdata_d = s_axis_tdata;
        m_tlast_d = s_axis_tlast;
      end
    end
  end

  // Stream-side state registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      open_q     <= 1'b0;
      pass_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tdata_q  <= '0;
      m_tlast_q  <= 1'b0;
    end else begin
      open_q     <= open_d;
      pass_q     <= pass_d;
      m_tvalid_q <= m_tvalid_d;
      m_tdata_q  <= m_tdata_d;
      m_tlast_q  <= m_tlast_d;
    end
  end

  // Forensics captured on the edge that accepts a dropped header.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      viol_q     <= '0;
      snap_q     <= '0;
      rsn_code_q <= '0;
      rsn_idx_q  <= '0;
    end else if (hdr && drop) begin
      if (viol_q != 32'hFFFF_FFFF) viol_q <= viol_q + 32'd1;
      snap_q     <= s_axis_tdata;
      rsn_code_q <= unknown ? 2'd2 : 2'd1;
      rsn_idx_q  <= hdr_idx;
    end
  end

  // Per-destination shadow limits, active limits and exposure accumulators.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_DEST; i++) begin
        limit_q[i] <= LIMIT_RST;
        act_q[i]   <= LIMIT_RST;
        exp_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_DEST; i++) begin
        if (lim_wr && wr_idx == IDX_W'(i))
          limit_q[i] <= strb_merge(limit_q[i], s_axil_wdata, s_axil_wstrb);
        if (lim_upd) act_q[i] <= limit_q[i];
        if (clr_exp) exp_q[i] <= '0;
        else if (acc_en && hdr_idx == IDX_W'(i)) exp_q[i] <= sat_acc(expo_c);
      end
    end
  end

  // Register read multiplexer.
  always_comb begin
    rd_val = 32'd0;
    rd_exp = 64'd0;
    if (ra == 12'h000)      rd_val = {28'd0, ctrl_q};
    else if (ra == 12'h004) rd_val = viol_q;
    else if (ra == 12'h008) rd_val = snap_q[31:0];
    else if (ra == 12'h00C) rd_val = snap_q[63:32];
    else if (ra == 12'h010) rd_val = {10'd0, 6'(rsn_idx_q), 14'd0, rsn_code_q};
    else if (ra[11:8] == 4'h1 && rd_lim_ok) rd_val = limit_q[ra[2 +: IDX_W]];
    else if (ra[11:9] == 3'b001 && rd_exp_ok) begin
      rd_exp = 64'(exp_q[ra[3 +: IDX_W]]);
      rd_val = ra[2] ? rd_exp[63:32] : rd_exp[31:0];
    end
  end

  // AXI-Lite handshakes and CTRL register; clear-exposure bit is never stored.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      ctrl_q    <= 4'h1;
    end else begin
      awready_q <= s_axil_awvalid && s_axil_wvalid && !awready_q && !bvalid_q;
      if (wr_fire)            bvalid_q <= 1'b1;
      else if (s_axil_bready) bvalid_q <= 1'b0;
      arready_q <= s_axil_arvalid && !arready_q && !rvalid_q;
      if (rd_fire) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (s_axil_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ctrl_wr && s_axil_wstrb[0])
        ctrl_q <= {s_axil_wdata[3], 1'b0, s_axil_wdata[1:0]};
    end
  end
endmodule

// File: tb/tb_sentinel_multi_limit.sv
// Self-checking bench for sentinel_multi_limit: scoreboard of forwarded beats,
// table-driven single-beat decisions and hand-written multi-cycle sequences.
module tb_sentinel_multi_limit;
  logic        aclk = 1'b0, aresetn = 1'b0;
  logic [63:0] s_tdata = '0, m_tdata;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic        m_tvalid, m_tlast, m_tready = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = 4'hF;
  logic        awvalid = 1'b0, awready, wvalid = 1'b0, wready, bvalid, bready = 1'b0;
  logic        arvalid = 1'b0, arready, rvalid, rready = 1'b0;
  logic [1:0]  bresp, rresp;

  sentinel_multi_limit dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
    .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready)
  );

  always #5 aclk = ~aclk;

  int checks = 0, errors = 0;
  int exp_viol = 0;
  logic [64:0] sb[$];
  logic [64:0] sb_e;

  typedef struct packed {
    logic [15:0] dest;
    logic [39:0] amt;
    logic        pass;
    logic [31:0] reason;
  } vec_t;
  vec_t tbl [0:6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s: timed out", nm);
  endtask

  function automatic logic [63:0] hdr(input logic [7:0] tag, input logic [15:0] dest,
                                      input logic [39:0] amt);
    return {tag, dest, amt};
  endfunction

  // Scoreboard: every beat leaving m_axis must match the oldest expected beat.
  always @(negedge aclk) begin
    if (aresetn && m_tvalid && m_tready) begin
      if (sb.size() == 0) begin
        timeout("unexpected_beat");
      end else begin
        sb_e = sb.pop_front();
        chk("beat_data", m_tdata, sb_e[63:0]);
        chk("beat_last", 64'(m_tlast), 64'(sb_e[64]));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last, input logic pass);
    s_tdata = d; s_tlast = last; s_tvalid = 1'b1;
    if (pass) sb.push_back({last, d});
    for (int n = 0; n < 300; n++) begin
      @(negedge aclk);
      if (s_tready) begin
        @(posedge aclk); #1;
        s_tvalid = 1'b0;
        return;
      end
      @(posedge aclk); #1;
    end
    s_tvalid = 1'b0;
    timeout("stream_accept");
  endtask

  task automatic send_pkt(input logic [7:0] tag, input logic [15:0] dest, input logic [39:0] amt,
                          input int nb, input logic pass);
    for (int b = 0; b < nb; b++) begin
      if (b == 0) send_beat(hdr(tag, dest, amt), (nb == 1), pass);
      else send_beat({tag, 8'(b), 16'hBEEF, $urandom()}, (b == nb - 1), pass);
    end
  endtask

  task automatic axil_write(input logic [11:0] a, input logic [31:0] d);
    logic got;
    awaddr = {20'd0, a}; wdata = d; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      got = awready;
      @(posedge aclk); #1;
    end
    awvalid = 1'b0; wvalid = 1'b0;
    if (!got) begin timeout("aw_handshake"); return; end
    bready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      got = bvalid;
      @(posedge aclk); #1;
    end
    bready = 1'b0;
    if (!got) timeout("b_response");
  endtask

  task automatic axil_read(input logic [11:0] a, output logic [31:0] d, output logic [1:0] r);
    logic got;
    d = 32'hDEAD_0000; r = 2'b11;
    araddr = {20'd0, a}; arvalid = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      got = arready;
      @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    if (!got) begin timeout("ar_handshake"); return; end
    rready = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge aclk);
      got = rvalid;
      if (got) begin d = rdata; r = rresp; end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    if (!got) timeout("r_response");
  endtask

  task automatic rd_chk(input string nm, input logic [11:0] a, input logic [31:0] req);
    logic [31:0] d;
    logic [1:0]  r;
    axil_read(a, d, r);
    chk(nm, 64'(d), 64'(req));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [1:0]  r;
    logic [63:0] h;
    logic        done;
    int          nb;
    logic [39:0] amt;
    logic [15:0] dst;

    tbl[0] = '{dest: 16'd3, amt: 40'd0,             pass: 1'b1, reason: 32'h0};
    tbl[1] = '{dest: 16'd7, amt: 40'd1000,          pass: 1'b1, reason: 32'h0};
    tbl[2] = '{dest: 16'd0, amt: 40'd999,           pass: 1'b1, reason: 32'h0};
    tbl[3] = '{dest: 16'd5, amt: 40'hFF_FFFF_FFFF,  pass: 1'b0, reason: 32'h0005_0001};
    tbl[4] = '{dest: 16'd1, amt: 40'd1001,          pass: 1'b0, reason: 32'h0001_0001};
    tbl[5] = '{dest: 16'd8, amt: 40'd5,             pass: 1'b0, reason: 32'h0000_0002};
    tbl[6] = '{dest: 16'd6, amt: 40'd1,             pass: 1'b1, reason: 32'h0};

    // Reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("rst_s_tready", 64'(s_tready), 64'd1);
    chk("rst_axil_out", 64'({awready, wready, bvalid, arready, rvalid, rdata}), 64'd0);
    aresetn = 1'b1;
    idle(2);
    rd_chk("rst_ctrl", 12'h000, 32'h1);
    rd_chk("rst_viol", 12'h004, 32'h0);
    rd_chk("rst_limit3", 12'h10C, 32'd1000);
    rd_chk("rst_exp0", 12'h200, 32'h0);

    // Mode 0 strict: 1000 passes with 1-cycle latency, 1001 drops
    axil_write(12'h000, 32'h9);
    idle(2);
    h = hdr(8'hA1, 16'd3, 40'd1000);
    send_beat(h, 1'b1, 1'b1);
    chk("latency_valid", 64'(m_tvalid), 64'd1);
    chk("latency_data", m_tdata, h);
    h = hdr(8'hA2, 16'd3, 40'd1001);
    send_beat(h, 1'b1, 1'b0);
    exp_viol++;
    idle(2);
    rd_chk("m0_viol", 12'h004, 32'd1);
    rd_chk("m0_snap_lo", 12'h008, h[31:0]);
    rd_chk("m0_snap_hi", 12'h00C, h[63:32]);
    rd_chk("m0_reason", 12'h010, 32'h0003_0001);

    // Table-driven single-beat decisions
    for (int i = 0; i <= 6; i++) begin
      h = hdr(8'(8'hB0 + i), tbl[i].dest, tbl[i].amt);
      send_beat(h, 1'b1, tbl[i].pass);
      if (!tbl[i].pass) begin
        exp_viol++;
        rd_chk("tbl_reason", 12'h010, tbl[i].reason);
        rd_chk("tbl_snap_lo", 12'h008, h[31:0]);
      end
    end
    idle(3);
    chk("tbl_drain", 64'(sb.size()), 64'd0);
    rd_chk("tbl_viol", 12'h004, 32'(exp_viol));

    // Mode 1 cumulative exposure on dest 2, then clear
    axil_write(12'h108, 32'd500);
    axil_write(12'h000, 32'h3);
    idle(2);
    send_pkt(8'hC0, 16'd2, 40'd200, 1, 1'b1);
    send_pkt(8'hC1, 16'd2, 40'd300, 1, 1'b1);
    idle(2);
    rd_chk("m1_exp_lo", 12'h210, 32'd500);
    rd_chk("m1_exp_hi", 12'h214, 32'd0);
    send_pkt(8'hC2, 16'd2, 40'd1, 1, 1'b0);
    exp_viol++;
    idle(2);
    rd_chk("m1_reason", 12'h010, 32'h0002_0001);
    axil_write(12'h000, 32'h7);
    idle(2);
    rd_chk("m1_ctrl_selfclr", 12'h000, 32'h3);
    rd_chk("m1_exp_cleared", 12'h210, 32'd0);
    send_pkt(8'hC3, 16'd2, 40'd1, 1, 1'b1);
    idle(2);
    rd_chk("m1_exp_after", 12'h210, 32'd1);
    axil_write(12'h108, 32'd1000);

    // Hitless update: LIMIT[0] rewritten while beat 2 is stalled
    axil_write(12'h000, 32'h1);
    idle(2);
    send_beat(hdr(8'hD0, 16'd0, 40'd800), 1'b0, 1'b1);
    send_beat(64'hD1D1_0000_0000_0001, 1'b0, 1'b1);
    m_tready = 1'b0;
    fork
      send_beat(64'hD1D1_0000_0000_0002, 1'b0, 1'b1);
      begin
        axil_write(12'h100, 32'd100);
        chk("stall_s_tready", 64'(s_tready), 64'd0);
        m_tready = 1'b1;
      end
    join
    send_beat(64'hD1D1_0000_0000_0003, 1'b1, 1'b1);
    idle(1);
    send_pkt(8'hD2, 16'd0, 40'd800, 1, 1'b0);
    exp_viol++;
    idle(3);
    chk("hitless_drain", 64'(sb.size()), 64'd0);
    rd_chk("hitless_viol", 12'h004, 32'(exp_viol));
    axil_write(12'h100, 32'd1000);
    idle(2);

    // Multi-beat drop then a passing packet
    send_pkt(8'hE0, 16'd4, 40'd2000, 3, 1'b0);
    exp_viol++;
    send_pkt(8'hE1, 16'd4, 40'd10, 2, 1'b1);
    idle(3);
    chk("mbdrop_drain", 64'(sb.size()), 64'd0);
    rd_chk("mbdrop_viol", 12'h004, 32'(exp_viol));

    // Strict vs non-strict for dest_id 9
    axil_write(12'h104, 32'd10);
    axil_write(12'h000, 32'h9);
    idle(2);
    send_pkt(8'hF0, 16'd9, 40'd5, 1, 1'b0);
    exp_viol++;
    idle(2);
    rd_chk("strict_reason", 12'h010, 32'h0001_0002);
    axil_write(12'h000, 32'h1);
    idle(2);
    send_pkt(8'hF1, 16'd9, 40'd5, 1, 1'b1);
    send_pkt(8'hF2, 16'd9, 40'd11, 1, 1'b0);
    exp_viol++;
    idle(2);
    rd_chk("nonstrict_reason", 12'h010, 32'h0001_0001);
    axil_write(12'h104, 32'd1000);
    idle(2);

    // Random backpressure under full load
    done = 1'b0;
    fork
      while (!done) begin
        @(posedge aclk); #1;
        m_tready = 1'($urandom_range(0, 1));
      end
      begin
        for (int p = 0; p < 30; p++) begin
          nb  = int'($urandom_range(1, 4));
          amt = 40'($urandom_range(0, 1200));
          dst = 16'($urandom_range(0, 7));
          send_pkt(8'(p), dst, amt, nb, (amt <= 40'd1000));
          if (amt > 40'd1000) exp_viol++;
        end
        done = 1'b1;
      end
    join
    m_tready = 1'b1;
    idle(10);
    chk("bp_drain", 64'(sb.size()), 64'd0);
    rd_chk("bp_viol", 12'h004, 32'(exp_viol));

    // AXI-Lite unmapped and read-only accesses
    axil_read(12'h300, d, r);
    chk("unmapped_data", 64'(d), 64'd0);
    chk("unmapped_resp", 64'(r), 64'd0);
    axil_write(12'h004, 32'h0);
    rd_chk("ro_viol_kept", 12'h004, 32'(exp_viol));

    // Reset mid-packet with a beat held on the output
    send_beat(hdr(8'h90, 16'd2, 40'd5), 1'b0, 1'b1);
    send_beat(64'h9191_0000_0000_0001, 1'b0, 1'b1);
    m_tready = 1'b0;
    @(posedge aclk); #3;
    aresetn = 1'b0;
    sb.delete();
    exp_viol = 0;
    #1;
    chk("mrst_m_tvalid", 64'(m_tvalid), 64'd0);
    chk("mrst_m_data", {m_tdata}, 64'd0);
    chk("mrst_m_last", 64'(m_tlast), 64'd0);
    chk("mrst_s_tready", 64'(s_tready), 64'd1);
    @(posedge aclk); #1;
    aresetn = 1'b1;
    m_tready = 1'b1;
    idle(1);
    rd_chk("mrst_ctrl", 12'h000, 32'h1);
    rd_chk("mrst_viol", 12'h004, 32'h0);
    rd_chk("mrst_exp2", 12'h210, 32'h0);
    send_pkt(8'h92, 16'd0, 40'd2000, 1, 1'b0);
    exp_viol++;
    send_pkt(8'h93, 16'd0, 40'd5, 1, 1'b1);
    idle(3);
    rd_chk("mrst_hdr_viol", 12'h004, 32'(exp_viol));
    chk("mrst_drain", 64'(sb.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/sentinel_multi_limit.md
# sentinel_multi_limit

Parametrised successor to the single-limit risk gate. It sits inline on the 64-bit order AXI4-Stream, between the ingress parser and the egress MAC. It enforces an independent limit per destination, in either per-transaction mode or cumulative-exposure mode, and makes one decision per packet. Limits are hitless-updated at packet boundaries, and per-destination exposure and forensic registers are visible over AXI4-Lite.

## Interface
- NUM_DEST, 8: number of destination channels; power of 2, 2..64.
- AMT_W, 40: amount field width, tdata[AMT_W-1:0].
- ID_LSB, 40: bit position of dest_id in tdata; dest_id is 16 bits.
- EXP_W, 48: per-destination exposure accumulator width, ≤64.
- aclk, input, 1: single clock for all logic.
- aresetn, input, 1: asynchronous, active-low reset.
- s_axis_tdata / tvalid / tlast / tready: in, in, in, out; widths 64, 1, 1, 1; order ingress.
- m_axis_tdata / tvalid / tlast / tready: out, out, out, in; widths 64, 1, 1, 1; order egress.
- s_axil_aw*/w*/b*/ar*/r*: standard AXI4-Lite slave. Addresses and data are 32-bit, resp is 2-bit.

## Operation
- Register map, decoded on awaddr/araddr[11:0]:
  - 0x000 CTRL: bit0 enable, bit1 cumulative mode, bit2 clear exposure (write-1, self-clearing, reads 0), bit3 strict dest. Reset value 0x1.
  - 0x004 VIOL_CNT: read-only, saturates at 0xFFFF_FFFF.
  - 0x008/0x00C SNAP_LO/HI: read-only. Holds the first beat of the last dropped packet.
  - 0x010 REASON: read-only. [1:0] = 1 over-limit, 2 unknown dest; [21:16] = dest index.
  - 0x100+4i LIMIT[i]: shadow limit, reset 1000.
  - 0x200+8i / 0x204+8i EXP_LO[i]/EXP_HI[i]: read-only.
  - Writes to read-only or unmapped addresses are ignored. Unmapped reads return 0. Every response is OKAY.
- AXI-Lite write: accepted only when awvalid and wvalid are both high and no response is pending. awready and wready pulse high together for 1 cycle. bvalid is asserted on the next cycle and held until bready.
- AXI-Lite read: arready pulses high for 1 cycle. rvalid is asserted on the next cycle and held until rready. Only one transaction is outstanding per channel.
- Packet decision:
  - The first beat of a packet is the header. It carries the amount and dest_id.
  - Dest index = dest_id[log2(NUM_DEST)-1:0].
  - Unknown dest means dest_id ≥ NUM_DEST and strict=1.
  - Over-limit means one of:
    - mode 0: amount > {0, active_limit[idx]}
    - mode 1: exposure[idx] + amount > active_limit[idx]
  - The comparison is unsigned and computed in EXP_W+1 bits, with limits zero-extended.
  - enable=0: every packet passes, and exposure is untouched.
- The decision is latched on the header beat and applies to every beat up to and including tlast. Dropped packets emit no beats.
- On a dropped header:
  - VIOL_CNT increments.
  - SNAP captures the header beat.
  - REASON is updated. Unknown dest takes priority over over-limit.
- On a passed header in mode 1: exposure[idx] += amount, saturating at 2^EXP_W−1.
- Clear exposure zeroes all channels. If a clear and an accumulation land in the same cycle, the clear wins.
- Hitless update: active_limit[i] ← LIMIT[i] on any cycle in which one of the following holds:
  - no packet is open and no header is accepted, or
  - an accepted beat carries tlast, or
  - enable=0.
- Mid-packet stalls and gaps never change the active limits.

## Timing
- Accepted beat = s_axis_tvalid & s_axis_tready.
- s_axis_tready = m_axis_tready | !m_axis_tvalid. This is combinational and has no combinational path from s_axis_tvalid.
- Latency is 1 cycle: an accepted passing beat appears on m_axis on the next edge. m_axis data and last stay stable while tvalid=1 and tready=0.
- Forensic and exposure registers update on the edge that accepts the header. CTRL and LIMIT update on the edge after the write is accepted.
- Reset values:
  - m_axis_tvalid, m_axis_tdata and m_axis_tlast are 0.
  - All AXI-Lite outputs are 0.
  - s_axis_tready is 1.
  - Packet-open flag is 0, exposures are 0, active limits are 1000.
- A reset mid-packet discards the open packet and any beat held on the output. The next accepted beat is treated as a header.
- Single-beat packets (header with tlast) are legal and are decided in that same cycle.

## Test plan
- Mode 0, strict, NUM_DEST=8:
  - Stimulus: single-beat packets, dest 3, amounts 1000 and 1001.
  - Required: the first is forwarded 1 cycle later; the second is dropped, VIOL_CNT=1, SNAP equals that beat, REASON=0x0003_0001.
- Mode 1, LIMIT[2]=500:
  - Stimulus: amounts 200, 300, 1 to dest 2.
  - Required: the first two pass, EXP[2]=500; the third is dropped.
  - Then write CTRL=0x7 and resend 1: it passes, EXP[2]=1.
- Hitless update:
  - Stimulus: 4-beat packet at dest 0, header amount 800. Write LIMIT[0]=100 while beat 2 is stalled by m_axis_tready=0.
  - Required: all 4 beats are forwarded with tlast on beat 4; the next packet with amount 800 is dropped.
- Multi-beat drop:
  - Stimulus: 3-beat packet, header over limit.
  - Required: no m_axis_tvalid for the whole packet; VIOL_CNT increments once; the following packet passes.
- Strict dest:
  - Stimulus: dest_id=9 with strict=1, then the same with strict=0.
  - Required: dropped with REASON[1:0]=2; then checked as dest 1.
- Backpressure, AXI-Lite and reset:
  - Stimulus: random m_axis_tready toggling under full stream load.
  - Required: no beat lost or duplicated.
  - Required: read of 0x300 returns 0 with OKAY.
  - Required: asserting aresetn low mid-packet restores every reset value and the next beat is treated as a header.
